// File: rtl/instruction_fetch.sv
// Fetch stage: one word read per instruction on a valid/ready memory port,
// held for decode behind a valid/ready handshake; flush drops in-flight work.
//
// state  | meaning
// ISSUE  | request word at program counter (or fault if misaligned)
// WAIT   | request accepted, awaiting response
// HOLD   | instruction register live, waiting for decode
// DRAIN  | flushed while outstanding; swallow the response
// FAULT  | misaligned PC seen; stuck until reset
module instruction_fetch #(
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [ADDRESS_WIDTH-1:0] i_program_counter,
  input  logic                     i_flush,
  output logic                     o_memory_request_valid,
  input  logic                     i_memory_request_ready,
  output logic [ADDRESS_WIDTH-1:0] o_memory_address,
  input  logic                     i_memory_response_valid,
  input  logic [31:0]              i_memory_response_data,
  output logic                     o_instruction_valid,
  input  logic                     i_instruction_ready,
  output logic [31:0]              o_instruction,
  output logic [ADDRESS_WIDTH-1:0] o_instruction_address,
  output logic                     o_advance,
  output logic                     o_misaligned
);

  typedef enum logic [2:0] {
    S_ISSUE = 3'd0,
    S_WAIT  = 3'd1,
    S_HOLD  = 3'd2,
    S_DRAIN = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t                     r_state;
  logic [ADDRESS_WIDTH-1:0]   r_fetch_address;
  logic                       r_instruction_valid;
  logic [31:0]                r_instruction;
  logic [ADDRESS_WIDTH-1:0]   r_instruction_address;
  logic                       r_misaligned;

  logic                       w_aligned;
  logic                       w_request_fire;

  assign w_aligned      = (i_program_counter[1:0] == 2'b00);
  assign w_request_fire = o_memory_request_valid & i_memory_request_ready;

  // Request and advance are combinational so a handshake costs no extra cycle;
  // both are masked while reset is asserted.
  assign o_memory_request_valid = ~i_reset & (r_state == S_ISSUE) & w_aligned;
  assign o_memory_address       = i_program_counter;
  assign o_advance              = ~i_reset & (r_state == S_HOLD) & i_instruction_ready & ~i_flush;

  assign o_instruction_valid   = r_instruction_valid;
  assign o_instruction         = r_instruction;
  assign o_instruction_address = r_instruction_address;
  assign o_misaligned          = r_misaligned;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state               <= S_ISSUE;
      r_fetch_address       <= '0;
      r_instruction_valid   <= 1'b0;
      r_instruction         <= 32'h0;
      r_instruction_address <= '0;
      r_misaligned          <= 1'b0;
    end else begin
      case (r_state)
        S_ISSUE: begin
          if (!w_aligned) begin
            r_misaligned <= 1'b1;
            r_state      <= S_FAULT;
          end else if (w_request_fire) begin
            r_fetch_address <= i_program_counter;
            r_state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_memory_response_valid) begin
            if (i_flush) begin
              r_state <= S_ISSUE;
            end else begin
              r_instruction         <= i_memory_response_data;
              r_instruction_address <= r_fetch_address;
              r_instruction_valid   <= 1'b1;
              r_state               <= S_HOLD;
            end
          end else if (i_flush) begin
            r_state <= S_DRAIN;
          end
        end
        S_HOLD: begin
          if (i_flush || i_instruction_ready) begin
            r_instruction_valid <= 1'b0;
            r_state             <= S_ISSUE;
          end
        end
        S_DRAIN: begin
          if (i_memory_response_valid) begin
            r_state <= S_ISSUE;
          end
        end
        S_FAULT: begin
          r_misaligned <= 1'b1;
        end
        default: begin
          r_state <= S_ISSUE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a one-outstanding memory model with
// programmable latency and a queue of instructions decode should receive.
module tb_instruction_fetch;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pc;
  logic          flush;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          resp_valid;
  logic [31:0]   resp_data;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr;
  logic [AW-1:0] instr_addr;
  logic          advance;
  logic          misaligned;

  always #5 clk = ~clk;

  instruction_fetch #(.ADDRESS_WIDTH(AW)) dut (
    .i_clock                 (clk),
    .i_reset                 (rst),
    .i_program_counter       (pc),
    .i_flush                 (flush),
    .o_memory_request_valid  (req_valid),
    .i_memory_request_ready  (req_ready),
    .o_memory_address        (req_addr),
    .i_memory_response_valid (resp_valid),
    .i_memory_response_data  (resp_data),
    .o_instruction_valid     (instr_valid),
    .i_instruction_ready     (instr_ready),
    .o_instruction           (instr),
    .o_instruction_address   (instr_addr),
    .o_advance               (advance),
    .o_misaligned            (misaligned)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  bit          m_pending, m_killed, m_held, m_fault;
  int          m_cnt;
  int          lat = 1;
  logic [31:0] m_data, m_addr;
  bit          force_en = 1'b0;
  logic [31:0] force_data = 32'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {~a[15:0], a[15:0]};
  endfunction

  // One clock cycle: drive memory response, check at negedge, update model.
  task automatic step();
    bit   resp_now;
    bit   exp_req;
    bit   exp_adv;
    exp_t front;
    resp_now = 1'b0;
    exp_adv  = 1'b0;
    if (m_pending) begin
      m_cnt--;
      if (m_cnt == 0) resp_now = 1'b1;
    end
    resp_valid = resp_now;
    resp_data  = resp_now ? m_data : 32'h0;
    @(negedge clk);
    exp_req = !m_pending && !m_held && !m_fault && (pc[1:0] == 2'b00);
    exp_adv = m_held && instr_ready && !flush;
    chk("req_valid", 64'(req_valid), 64'(exp_req));
    if (exp_req) chk("req_addr", 64'(req_addr), 64'(pc));
    chk("instr_valid", 64'(instr_valid), 64'(m_held));
    chk("advance", 64'(advance), 64'(exp_adv));
    chk("misaligned", 64'(misaligned), 64'(m_fault));
    if (m_held) begin
      front = sb_q[0];
      chk("instr", 64'(instr), 64'(front.data));
      chk("instr_addr", 64'(instr_addr), 64'(front.addr));
    end
    if (!m_pending && !m_held && !m_fault && pc[1:0] != 2'b00) m_fault = 1'b1;
    if (m_held && (instr_ready || flush)) begin
      void'(sb_q.pop_front());
      m_held = 1'b0;
    end
    if (m_pending && flush) m_killed = 1'b1;
    if (resp_now) begin
      m_pending = 1'b0;
      if (!m_killed) begin
        sb_q.push_back('{data: m_data, addr: m_addr});
        m_held = 1'b1;
      end
    end
    if (exp_req && req_ready) begin
      m_pending = 1'b1;
      m_killed  = 1'b0;
      m_cnt     = lat;
      m_addr    = pc;
      m_data    = force_en ? force_data : mem_word(pc);
    end
    @(posedge clk);
    #1;
    if (exp_adv) pc = pc + 32'd4;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    flush      = 1'b0;
    resp_valid = 1'b0;
    resp_data  = 32'h0;
    m_pending  = 1'b0;
    m_held     = 1'b0;
    m_fault    = 1'b0;
    m_killed   = 1'b0;
    sb_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_instr_addr", 64'(instr_addr), 64'd0);
    chk("rst_advance", 64'(advance), 64'd0);
    chk("rst_misaligned", 64'(misaligned), 64'd0);
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && (m_pending || m_held); i++) step();
    chk("idle_timeout", 64'(m_pending || m_held), 64'd0);
  endtask

  task automatic wait_held();
    for (int i = 0; i < 20 && !m_held; i++) step();
    chk("hold_timeout", 64'(m_held), 64'd1);
  endtask

  initial begin
    rst         = 1'b0;
    pc          = 32'h0;
    flush       = 1'b0;
    req_ready   = 1'b1;
    instr_ready = 1'b1;
    resp_valid  = 1'b0;
    resp_data   = 32'h0;
    do_reset();

    // first fetch: request c0, response c1, valid + advance c2
    pc = 32'h0;
    lat = 1;
    repeat (3) step();
    chk("first_advanced_pc", 64'(pc), 64'h4);
    step();

    // mixed traffic
    for (int i = 0; i < 40; i++) begin
      lat         = int'($urandom_range(1, 3));
      req_ready   = 1'($urandom_range(0, 1));
      instr_ready = 1'($urandom_range(0, 1));
      flush       = ($urandom_range(0, 7) == 0);
      step();
    end
    flush       = 1'b0;
    req_ready   = 1'b1;
    instr_ready = 1'b1;
    wait_idle();

    // decode backpressure
    pc = 32'h100;
    lat = 1;
    instr_ready = 1'b0;
    wait_held();
    repeat (4) step();
    instr_ready = 1'b1;
    step();
    chk("bp_pc_stepped", 64'(pc), 64'h104);
    wait_idle();

    // flush while waiting, late response swallowed, refetch from new PC
    pc = 32'h20;
    lat = 4;
    force_en = 1'b1;
    force_data = 32'hDEAD_BEEF;
    step();
    force_en = 1'b0;
    flush = 1'b1;
    pc = 32'h40;
    step();
    flush = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    lat = 1;
    step();
    wait_idle();

    // flush coincident with response
    pc = 32'h80;
    lat = 2;
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    lat = 1;
    step();
    wait_idle();

    // flush coincident with decode ready in HOLD
    pc = 32'h90;
    instr_ready = 1'b0;
    wait_held();
    instr_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_hold_pc", 64'(pc), 64'h90);
    step();
    wait_idle();

    // memory not ready: address held
    pc = 32'h10;
    req_ready = 1'b0;
    repeat (5) step();
    req_ready = 1'b1;
    step();
    wait_idle();

    // reset with a request outstanding
    pc = 32'h30;
    lat = 3;
    step();
    step();
    do_reset();
    lat = 1;
    repeat (4) step();
    wait_idle();

    // misaligned PC: sticky fault, cleared by reset
    pc = 32'h6;
    repeat (6) step();
    do_reset();
    pc = 32'h0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
